overflow_adjust_unit: RTL and testbench

- Pipelined stage directly upstream of the reduction node in each PE column output path.
- Takes wide signed partial sums from the column adder tree and saturates them to ACCUM_WIDTH.
- Emits LSP (low lane) and MSP (high lane, sparse mode only), which the reduction node combines.
- Tracks overflow events with a sticky flag and a saturating event counter.

---
 rtl/overflow_adjust_unit.sv | 138 +++++++++++++
 tb/tb_overflow_adjust_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/overflow_adjust_unit.sv
// Saturates wide signed column partial sums to ACCUM_WIDTH lanes (LSP/MSP) and tracks overflow status.
// Latency: 2 cycles input handshake to out_valid (S1 capture, S2 output register), 1 beat/cycle.
// Backpressure: out_ready low holds S2; S1 fills only if empty; in_ready = S1 can advance.
module overflow_adjust_unit #(
  parameter int ACCUM_WIDTH = 32,
  parameter int GUARD_BITS  = 8,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              in_sparse_en,
  input  logic [ACCUM_WIDTH+GUARD_BITS-1:0] in_psum_lo,
  input  logic [ACCUM_WIDTH+GUARD_BITS-1:0] in_psum_hi,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [ACCUM_WIDTH-1:0]            out_lsp,
  output logic [ACCUM_WIDTH-1:0]            out_msp,
  output logic                              out_sparse_en,
  output logic                              out_ovf_lo,
  output logic                              out_ovf_hi,
  input  logic                              clr_status,
  output logic                              ovf_sticky,
  output logic [CNT_WIDTH-1:0]              ovf_count
);

  localparam int AW = ACCUM_WIDTH;
  localparam int IW = ACCUM_WIDTH + GUARD_BITS;

  typedef struct packed {
    logic          sparse;
    logic [IW-1:0] lo;
    logic [IW-1:0] hi;
  } s1_t;

  typedef struct packed {
    logic          sparse;
    logic          ovf_lo;
    logic          ovf_hi;
    logic [AW-1:0] lsp;
    logic [AW-1:0] msp;
  } s2_t;

  // Returns {ovf, value}. The value fits when the guard bits plus the
  // result sign bit are all copies of the input sign bit.
  function automatic logic [AW:0] saturate(input logic [IW-1:0] x);
    logic [AW-1:0] v;
    logic          o;
    if (x[IW-1:AW-1] == {(GUARD_BITS+1){x[IW-1]}}) begin
      v = x[AW-1:0];
      o = 1'b0;
    end else begin
      v = x[IW-1] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
      o = 1'b1;
    end
    return {o, v};
  endfunction

  logic s1_valid, s2_valid;
  s1_t  s1_q;
  s2_t  s2_q, s2_next;
  logic s1_adv, s2_adv;
  logic [AW:0] sat_lo, sat_hi;
  logic [1:0]           ovf_inc;
  logic [CNT_WIDTH:0]   cnt_sum;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic                 out_xfer;

  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;
  assign out_xfer = s2_valid && out_ready;

  // Saturate the S1 lanes; the high lane is forced to zero in dense mode.
  always_comb begin
    sat_lo         = saturate(s1_q.lo);
    sat_hi         = s1_q.sparse ? saturate(s1_q.hi) : '0;
    s2_next        = '0;
    s2_next.sparse = s1_q.sparse;
    s2_next.ovf_lo = sat_lo[AW];
    s2_next.ovf_hi = sat_hi[AW];
    s2_next.lsp    = sat_lo[AW-1:0];
    s2_next.msp    = sat_hi[AW-1:0];
  end

  // Next overflow count: add 0..2 saturated lanes, clamp at all-ones.
  always_comb begin
    ovf_inc  = {1'b0, s2_q.ovf_lo} + {1'b0, s2_q.ovf_hi};
    cnt_sum  = {1'b0, ovf_count} + {{(CNT_WIDTH-1){1'b0}}, ovf_inc};
    cnt_next = cnt_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : cnt_sum[CNT_WIDTH-1:0];
  end

  // Two-stage pipeline; each stage loads only when it can advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_q     <= '0;
      s2_q     <= '0;
    end else begin
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_q <= s2_next;
      end
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_q.sparse <= in_sparse_en;
          s1_q.lo     <= in_psum_lo;
          s1_q.hi     <= in_psum_hi;
        end
      end
    end
  end

  // Overflow status advances on output transfers; clear wins over increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
    end else if (clr_status) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
    end else if (out_xfer) begin
      if (s2_q.ovf_lo || s2_q.ovf_hi) ovf_sticky <= 1'b1;
      ovf_count <= cnt_next;
    end
  end

  assign out_valid     = s2_valid;
  assign out_lsp       = s2_q.lsp;
  assign out_msp       = s2_q.msp;
  assign out_sparse_en = s2_q.sparse;
  assign out_ovf_lo    = s2_q.ovf_lo;
  assign out_ovf_hi    = s2_q.ovf_hi;

endmodule

// File: tb/tb_overflow_adjust_unit.sv
module tb_overflow_adjust_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_sparse_en;
  logic [39:0] in_psum_lo, in_psum_hi;
  logic        out_valid, out_ready;
  logic [31:0] out_lsp, out_msp;
  logic        out_sparse_en, out_ovf_lo, out_ovf_hi;
  logic        clr_status, ovf_sticky;
  logic [15:0] ovf_count;

  overflow_adjust_unit #(.ACCUM_WIDTH(32), .GUARD_BITS(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sparse_en(in_sparse_en),
    .in_psum_lo(in_psum_lo), .in_psum_hi(in_psum_hi),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_lsp(out_lsp), .out_msp(out_msp), .out_sparse_en(out_sparse_en),
    .out_ovf_lo(out_ovf_lo), .out_ovf_hi(out_ovf_hi),
    .clr_status(clr_status), .ovf_sticky(ovf_sticky), .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] lsp;
    logic [31:0] msp;
    logic        sp;
    logic        olo;
    logic        ohi;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   model_cnt = 0;
  logic model_sticky = 1'b0;
  logic saw_ir_low = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send(input logic sp, input logic [39:0] lo, input logic [39:0] hi,
                      input logic [31:0] elsp, input logic [31:0] emsp,
                      input logic eolo, input logic eohi);
    int   n;
    logic acc;
    exp_t e;
    in_valid = 1'b1; in_sparse_en = sp; in_psum_lo = lo; in_psum_hi = hi;
    n = 0; acc = 1'b0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end
    if (acc) begin
      e.lsp = elsp; e.msp = emsp; e.sp = sp; e.olo = eolo; e.ohi = eohi;
      q.push_back(e);
    end else begin
      check("send_timeout", 64'(acc), 64'd1);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) check("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  // Monitor / scoreboard: samples on the falling edge.
  initial begin : monitor
    exp_t e;
    logic prev_stall;
    logic [31:0] p_lsp, p_msp;
    logic p_sp, p_olo, p_ohi;
    int inc;
    prev_stall = 1'b0;
    p_lsp = '0; p_msp = '0; p_sp = 0; p_olo = 0; p_ohi = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        model_cnt = 0; model_sticky = 1'b0; prev_stall = 1'b0;
      end else begin
        check("ovf_count", 64'(ovf_count), 64'(model_cnt));
        check("ovf_sticky", 64'(ovf_sticky), 64'(model_sticky));
        if (in_valid && !in_ready) saw_ir_low = 1'b1;
        if (prev_stall) begin
          check("hold_valid", 64'(out_valid), 64'd1);
          check("hold_data", {out_lsp, out_msp}, {p_lsp, p_msp});
          check("hold_flags", {61'd0, out_sparse_en, out_ovf_lo, out_ovf_hi}, {61'd0, p_sp, p_olo, p_ohi});
        end
        inc = 0;
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            check("unexpected_beat", 64'(out_valid), 64'd0);
          end else begin
            e = q.pop_front();
            check("lsp", 64'(out_lsp), 64'(e.lsp));
            check("msp", 64'(out_msp), 64'(e.msp));
            check("sparse_en", 64'(out_sparse_en), 64'(e.sp));
            check("ovf_lo", 64'(out_ovf_lo), 64'(e.olo));
            check("ovf_hi", 64'(out_ovf_hi), 64'(e.ohi));
            inc = int'(e.olo) + int'(e.ohi);
          end
        end
        if (clr_status) begin
          model_cnt = 0; model_sticky = 1'b0;
        end else if (inc != 0) begin
          model_cnt = (model_cnt + inc > 65535) ? 65535 : model_cnt + inc;
          model_sticky = 1'b1;
        end
        prev_stall = out_valid && !out_ready;
        p_lsp = out_lsp; p_msp = out_msp; p_sp = out_sparse_en; p_olo = out_ovf_lo; p_ohi = out_ovf_hi;
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  initial begin : stim
    rst_n = 1'b0; in_valid = 1'b0; in_sparse_en = 1'b0;
    in_psum_lo = '0; in_psum_hi = '0; out_ready = 1'b0; clr_status = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_data", {out_lsp, out_msp}, 64'd0);
    check("rst_flags", {61'd0, out_sparse_en, out_ovf_lo, out_ovf_hi}, 64'd0);
    check("rst_status", {47'd0, ovf_sticky, ovf_count}, 64'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Dense in-range beat, latency check.
    send(1'b0, 40'h00_0000_1234, 40'h00_0000_0000, 32'h0000_1234, 32'h0, 1'b0, 1'b0);
    check("lat_cycle1", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("lat_cycle2", 64'(out_valid), 64'd1);
    drain();
    check("dense_count", 64'(ovf_count), 64'd0);

    // Sparse, both lanes overflow.
    send(1'b1, 40'h00_8000_0000, 40'hFF_7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b1);
    drain();
    check("sparse_sticky", 64'(ovf_sticky), 64'd1);
    check("sparse_count", 64'(ovf_count), 64'd2);

    // Dense beat with out-of-range hi lane that must be ignored.
    send(1'b0, 40'h00_0000_0042, 40'h7F_FFFF_FFFF, 32'h0000_0042, 32'h0, 1'b0, 1'b0);
    drain();
    check("dense_hi_count", 64'(ovf_count), 64'd2);

    // Back-to-back stream with out_ready low on cycles 3-5.
    saw_ir_low = 1'b0;
    fork
      begin
        send(1'b0, 40'h00_0000_0001, 40'h0,           32'h0000_0001, 32'h0,         1'b0, 1'b0);
        send(1'b1, 40'h00_0000_0010, 40'hFF_FFFF_FFFF, 32'h0000_0010, 32'hFFFF_FFFF, 1'b0, 1'b0);
        send(1'b0, 40'hFF_FFFF_FFFE, 40'h12_3456_789A, 32'hFFFF_FFFE, 32'h0,         1'b0, 1'b0);
        send(1'b1, 40'h00_7FFF_FFFF, 40'hFF_8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b0);
        send(1'b1, 40'h01_0000_0000, 40'h00_0000_0005, 32'h7FFF_FFFF, 32'h0000_0005, 1'b1, 1'b0);
        send(1'b0, 40'h80_0000_0000, 40'h0,           32'h8000_0000, 32'h0,         1'b1, 1'b0);
        send(1'b1, 40'h00_0000_0AAA, 40'hFE_0000_0000, 32'h0000_0AAA, 32'h8000_0000, 1'b0, 1'b1);
        send(1'b0, 40'h00_5555_5555, 40'h0,           32'h5555_5555, 32'h0,         1'b0, 1'b0);
      end
      begin
        for (int c = 0; c < 12; c++) begin
          out_ready = !(c >= 3 && c <= 5);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    check("stream_in_ready_low", 64'(saw_ir_low), 64'd1);
    check("stream_count", 64'(ovf_count), 64'd5);

    // Drive the counter into saturation.
    for (int i = 0; i < 32768; i++)
      send(1'b1, 40'h00_8000_0000, 40'hFF_7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b1);
    drain();
    check("cnt_saturated", 64'(ovf_count), 64'hFFFF);
    send(1'b1, 40'h00_8000_0000, 40'hFF_7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b1);
    drain();
    check("cnt_held_max", 64'(ovf_count), 64'hFFFF);

    // clr_status coincident with an overflow transfer.
    out_ready = 1'b0;
    send(1'b0, 40'hC0_0000_0000, 40'h0, 32'h8000_0000, 32'h0, 1'b1, 1'b0);
    for (int n = 0; n < 20 && !out_valid; n++) begin
      @(posedge clk); #1;
    end
    check("clr_beat_ready", 64'(out_valid), 64'd1);
    clr_status = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    clr_status = 1'b0;
    check("clr_count", 64'(ovf_count), 64'd0);
    check("clr_sticky", 64'(ovf_sticky), 64'd0);
    drain();

    // Reset while both stages hold a beat.
    out_ready = 1'b0;
    send(1'b0, 40'h00_0000_0077, 40'h0, 32'h0000_0077, 32'h0, 1'b0, 1'b0);
    send(1'b1, 40'h00_0000_0088, 40'h00_0000_0099, 32'h0000_0088, 32'h0000_0099, 1'b0, 1'b0);
    check("pre_rst_full", {62'd0, out_valid, in_ready}, {62'd0, 1'b1, 1'b0});
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_lsp", 64'(out_lsp), 64'd0);
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_queue", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
